// File: rtl/cond_status_unit.sv
// Condition-code status register with a one-entry valid/ready result stage.
// Optional build macro FLAG_FWD_EN: same-edge s_load flags feed the evaluator.
module cond_status_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic       n_in,
    input  logic       z_in,
    input  logic       c_in,
    input  logic       v_in,
    input  logic       s_load,
    input  logic [3:0] cond,
    input  logic       eval_req,
    output logic       eval_ready,
    input  logic       out_ready,
    output logic       cond_valid,
    output logic       cond_true,
    output logic [3:0] sr,
    output logic       cin_out
);

    localparam int unsigned FLAG_W = 4;
    localparam int unsigned COND_W = 4;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic                true_q, true_d;
    logic [FLAG_W-1:0]   sr_q, sr_d;
    logic [FLAG_W-1:0]   alu_flags;
    logic [FLAG_W-1:0]   eval_flags;
    logic                accept;

    // Flags are packed {N,Z,C,V}
    function automatic logic eval_cond(input logic [COND_W-1:0] c, input logic [FLAG_W-1:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0:    return z;
            4'h1:    return !z;
            4'h2:    return cy;
            4'h3:    return !cy;
            4'h4:    return n;
            4'h5:    return !n;
            4'h6:    return v;
            4'h7:    return !v;
            4'h8:    return cy & !z;
            4'h9:    return !cy | z;
            4'hA:    return n == v;
            4'hB:    return n != v;
            4'hC:    return !z & (n == v);
            4'hD:    return z | (n != v);
            4'hE:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    assign alu_flags = {n_in, z_in, c_in, v_in};

`ifdef FLAG_FWD_EN
    assign eval_flags = s_load ? alu_flags : sr_q;
`else
    assign eval_flags = sr_q;
`endif

    assign eval_ready = (state_q == EMPTY) | out_ready;
    assign accept     = eval_req & eval_ready;

    // Next state for result stage and status register
    always_comb begin
        state_d = state_q;
        true_d  = true_q;
        sr_d    = sr_q;

        if (s_load) begin
            sr_d = alu_flags;
        end

        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = FULL;
                    true_d  = eval_cond(cond, eval_flags);
                end
            end
            FULL: begin
                if (accept) begin
                    true_d = eval_cond(cond, eval_flags);
                end else if (out_ready) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            true_q  <= 1'b0;
            sr_q    <= '0;
        end else begin
            state_q <= state_d;
            true_q  <= true_d;
            sr_q    <= sr_d;
        end
    end

    assign cond_valid = (state_q == FULL);
    assign cond_true  = true_q;
    assign sr         = sr_q;
    assign cin_out    = sr_q[1];

endmodule

// File: tb/tb_cond_status_unit.sv
// Self-checking bench for cond_status_unit: directed scenarios plus random traffic
// against a behavioural model of flags, handshake and condition table.
`timescale 1ns/1ps
module tb_cond_status_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       n_in, z_in, c_in, v_in;
    logic       s_load;
    logic [3:0] cond;
    logic       eval_req;
    logic       eval_ready;
    logic       out_ready;
    logic       cond_valid;
    logic       cond_true;
    logic [3:0] sr;
    logic       cin_out;

    int n_vec = 0;
    int n_err = 0;

    logic [3:0] m_sr;
    logic       m_valid;
    logic       m_true;

    always #5 clk = ~clk;

    cond_status_unit dut (
        .clk        (clk),
        .reset      (reset),
        .n_in       (n_in),
        .z_in       (z_in),
        .c_in       (c_in),
        .v_in       (v_in),
        .s_load     (s_load),
        .cond       (cond),
        .eval_req   (eval_req),
        .eval_ready (eval_ready),
        .out_ready  (out_ready),
        .cond_valid (cond_valid),
        .cond_true  (cond_true),
        .sr         (sr),
        .cin_out    (cin_out)
    );

    // Conditions come in true/negated pairs; odd codes invert the even base
    function automatic logic ref_eval(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, b;
        {n, z, cy, v} = f;
        case (c[3:1])
            3'd0: b = z;
            3'd1: b = cy;
            3'd2: b = n;
            3'd3: b = v;
            3'd4: b = cy && !z;
            3'd5: b = (n == v);
            3'd6: b = !z && (n == v);
            default: b = 1'b1;
        endcase
        return b ^ c[0];
    endfunction

    // One clock edge; model advances from the inputs present before it
    task automatic tick();
        logic       acc;
        logic       ld;
        logic       rst;
        logic       orr;
        logic [3:0] fl;
        logic [3:0] alu;
        logic [3:0] c;
        alu = {n_in, z_in, c_in, v_in};
        rst = reset;
        ld  = s_load;
        orr = out_ready;
        c   = cond;
        acc = eval_req && (!m_valid || out_ready);
        fl  = m_sr;
`ifdef FLAG_FWD_EN
        if (ld) fl = alu;
`endif
        @(posedge clk);
        #1;
        if (rst) begin
            m_sr = 4'b0000; m_valid = 1'b0; m_true = 1'b0;
        end else begin
            if (acc) begin
                m_true  = ref_eval(c, fl);
                m_valid = 1'b1;
            end else if (m_valid && orr) begin
                m_valid = 1'b0;
            end
            if (ld) m_sr = alu;
        end
    endtask

    task automatic idle_inputs();
        reset = 1'b0; s_load = 1'b0; eval_req = 1'b0; out_ready = 1'b1;
        cond = 4'h0; {n_in, z_in, c_in, v_in} = 4'b0000;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1; s_load = 1'b1; eval_req = 1'b1;
        {n_in, z_in, c_in, v_in} = 4'b1111;
        tick();
        idle_inputs();
        n_vec++;
        if (sr !== 4'b0000 || cond_valid !== 1'b0 || cond_true !== 1'b0 || cin_out !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: sr=%b valid=%b true=%b cin=%b, required 0000 0 0 0", sr, cond_valid, cond_true, cin_out);
        end
        out_ready = 1'b0;
        #1;
        n_vec++;
        if (eval_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready: eval_ready=%b, required 1", eval_ready);
        end
    endtask

    task automatic test_eq_basic();
        do_reset();
        s_load = 1'b1; {n_in, z_in, c_in, v_in} = 4'b0100;
        tick();
        s_load = 1'b0; {n_in, z_in, c_in, v_in} = 4'b0000;
        eval_req = 1'b1; cond = 4'h0; out_ready = 1'b1;
        tick();
        eval_req = 1'b0;
        n_vec++;
        if (cond_valid !== 1'b1 || cond_true !== 1'b1 || sr !== 4'b0100 || cin_out !== 1'b0) begin
            n_err++;
            $display("FAIL eq_basic: valid=%b true=%b sr=%b cin=%b, required 1 1 0100 0", cond_valid, cond_true, sr, cin_out);
        end
        tick();
    endtask

    task automatic test_sweep();
        int exp_tbl [16] = '{0,1,1,0,1,0,0,1,1,0,0,1,0,1,1,0};
        do_reset();
        s_load = 1'b1; {n_in, z_in, c_in, v_in} = 4'b1010;
        tick();
        s_load = 1'b0;
        for (int i = 0; i < 16; i++) begin
            {n_in, z_in, c_in, v_in} = 4'($urandom);
            eval_req = 1'b1; cond = 4'(i); out_ready = 1'b1;
            tick();
            n_vec++;
            if (cond_valid !== 1'b1 || cond_true !== 1'(exp_tbl[i])) begin
                n_err++;
                $display("FAIL sweep_cond_%0h: valid=%b true=%b, required 1 %0d", i, cond_valid, cond_true, exp_tbl[i]);
            end
        end
        eval_req = 1'b0;
        tick();
        n_vec++;
        if (cond_valid !== 1'b0) begin
            n_err++;
            $display("FAIL sweep_drain: valid=%b, required 0", cond_valid);
        end
    endtask

    task automatic test_stall();
        do_reset();
        eval_req = 1'b1; cond = 4'hE;
        tick();
        out_ready = 1'b0; cond = 4'hF;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++;
            if (eval_ready !== 1'b0) begin
                n_err++;
                $display("FAIL stall_ready_%0d: eval_ready=%b, required 0", i, eval_ready);
            end
            tick();
            n_vec++;
            if (cond_valid !== 1'b1 || cond_true !== 1'b1) begin
                n_err++;
                $display("FAIL stall_hold_%0d: valid=%b true=%b, required 1 1", i, cond_valid, cond_true);
            end
        end
        out_ready = 1'b1;
        #1;
        n_vec++;
        if (eval_ready !== 1'b1) begin
            n_err++;
            $display("FAIL stall_release_ready: eval_ready=%b, required 1", eval_ready);
        end
        tick();
        eval_req = 1'b0;
        n_vec++;
        if (cond_valid !== 1'b1 || cond_true !== 1'b0) begin
            n_err++;
            $display("FAIL stall_release: valid=%b true=%b, required 1 0", cond_valid, cond_true);
        end
        tick();
    endtask

    task automatic test_same_edge();
        logic exp_t;
`ifdef FLAG_FWD_EN
        exp_t = 1'b1;
`else
        exp_t = 1'b0;
`endif
        do_reset();
        s_load = 1'b1; {n_in, z_in, c_in, v_in} = 4'b0100;
        eval_req = 1'b1; cond = 4'h0; out_ready = 1'b1;
        tick();
        idle_inputs();
        n_vec++;
        if (cond_valid !== 1'b1 || cond_true !== exp_t || sr !== 4'b0100) begin
            n_err++;
            $display("FAIL same_edge: valid=%b true=%b sr=%b, required 1 %b 0100", cond_valid, cond_true, sr, exp_t);
        end
        tick();
    endtask

    task automatic test_reset_override();
        do_reset();
        eval_req = 1'b1; cond = 4'hE; out_ready = 1'b0;
        tick();
        eval_req = 1'b1;
        s_load = 1'b1; {n_in, z_in, c_in, v_in} = 4'b0010;
        reset = 1'b1;
        tick();
        idle_inputs();
        n_vec++;
        if (sr !== 4'b0000 || cond_valid !== 1'b0 || cin_out !== 1'b0) begin
            n_err++;
            $display("FAIL reset_override: sr=%b valid=%b cin=%b, required 0000 0 0", sr, cond_valid, cin_out);
        end
    endtask

    task automatic test_cin_hold();
        logic [3:0] loaded;
        do_reset();
        loaded = {1'($urandom), 1'($urandom), 1'b1, 1'($urandom)};
        s_load = 1'b1; {n_in, z_in, c_in, v_in} = loaded;
        tick();
        s_load = 1'b0;
        n_vec++;
        if (cin_out !== 1'b1 || sr !== loaded) begin
            n_err++;
            $display("FAIL cin_load: cin=%b sr=%b, required 1 %b", cin_out, sr, loaded);
        end
        for (int i = 0; i < 5; i++) begin
            {n_in, z_in, c_in, v_in} = 4'($urandom);
            tick();
            n_vec++;
            if (cin_out !== 1'b1 || sr !== loaded) begin
                n_err++;
                $display("FAIL cin_hold_%0d: cin=%b sr=%b, required 1 %b", i, cin_out, sr, loaded);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            reset     = ($urandom_range(0, 49) == 0);
            s_load    = 1'($urandom);
            {n_in, z_in, c_in, v_in} = 4'($urandom);
            cond      = 4'($urandom);
            eval_req  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            n_vec++;
            if (eval_ready !== (!m_valid || out_ready)) begin
                n_err++;
                $display("FAIL rand_ready_%0d: eval_ready=%b, required %b", i, eval_ready, !m_valid || out_ready);
            end
            tick();
            n_vec++;
            if (cond_valid !== m_valid || sr !== m_sr || cin_out !== m_sr[1] ||
                (m_valid && cond_true !== m_true)) begin
                n_err++;
                $display("FAIL rand_out_%0d: valid=%b true=%b sr=%b cin=%b, required %b %b %b %b",
                         i, cond_valid, cond_true, sr, cin_out, m_valid, m_true, m_sr, m_sr[1]);
            end
        end
        idle_inputs();
    endtask

    initial begin
        m_sr = 4'b0000; m_valid = 1'b0; m_true = 1'b0;
        idle_inputs();
        #1;
        test_reset();
        test_eq_basic();
        test_sweep();
        test_stall();
        test_same_edge();
        test_reset_override();
        test_cin_hold();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cond_status_unit.md
COND_STATUS_UNIT -- requirements
Module: cond_status_unit

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 n_in, z_in, c_in, v_in  input  1 each  condition flags from ALU (N, Z, C, V).
REQ-004 s_load  input  1  capture ALU flags into status register this edge.
REQ-005 cond  input  4  condition field to evaluate (encoding per REQ-013).
REQ-006 eval_req  input  1  request evaluation of cond.
REQ-007 eval_ready  output  1  unit accepts eval_req this cycle.
REQ-008 out_ready  input  1  consumer accepts cond_valid/cond_true this cycle.
REQ-009 cond_valid  output  1  registered result valid.
REQ-010 cond_true  output  1  registered result: condition satisfied.
REQ-011 sr  output  4  status register {N,Z,C,V}.
REQ-012 cin_out  output  1  carry to ALU Cin; equals sr C bit, combinational from register.

Function
REQ-013 cond encoding: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V); E AL 1; F NV 0.
REQ-014 s_load=1 at edge -> sr <= {n_in,z_in,c_in,v_in}; s_load=0 -> sr holds.
REQ-015 Output FSM states EMPTY (cond_valid=0) and FULL (cond_valid=1).
REQ-016 eval_ready = (state==EMPTY) | out_ready, combinational.
REQ-017 Accept = eval_req & eval_ready; on accept, cond_true <= eval(cond, flags) and state <= FULL; latency exactly 1 cycle.
REQ-018 FULL & out_ready & !accept -> EMPTY; FULL & !out_ready -> hold cond_valid and cond_true unchanged, eval_req ignored.
REQ-019 FULL & out_ready & accept -> stay FULL with new result (back-to-back, one result per cycle).
REQ-020 EMPTY & !eval_req -> stay EMPTY; cond_true holds last value (don't-care to consumer).
REQ-021 Flags used by eval: sr register value before the same-edge s_load update, unless REQ-026 applies.
REQ-022 s_load is independent of handshake; sr updates even while FULL and stalled; a held result is never re-evaluated.

Reset
REQ-023 reset=1 at edge -> sr=4'b0000, state EMPTY, cond_valid=0, cond_true=0; cin_out=0 follows.
REQ-024 reset overrides s_load and eval_req in same cycle; pending held result is discarded.
REQ-025 First edge after reset deassertion operates normally (eval_ready=1).

Configuration
REQ-026 FLAG_FWD_EN defined: when s_load and accept coincide, eval uses {n_in,z_in,c_in,v_in} (forwarded); not defined: eval uses registered sr per REQ-021.
REQ-027 FLAG_FWD_EN affects only eval flag source; sr, cin_out, handshake identical in both builds.

Verification
REQ-028 reset; s_load with N=0,Z=1,C=0,V=0; next cycle eval_req cond=0 (EQ), out_ready=1 -> one cycle later cond_valid=1, cond_true=1; sr=4'b0100, cin_out=0.
REQ-029 sr={N=1,Z=0,C=1,V=0}; sweep cond 0..F back-to-back, out_ready=1 -> cond_true per cycle: 0,1,1,0,1,0,0,1,1,0,0,1,0,1,1,0.
REQ-030 cond_valid=1, out_ready=0 for 3 cycles, eval_req=1 cond=F -> eval_ready=0, result unchanged 3 cycles; out_ready=1 -> next edge result from cond=F (cond_true=0).
REQ-031 sr=0, same edge s_load Z=1 and eval cond=0 -> cond_true=0 without FLAG_FWD_EN, 1 with FLAG_FWD_EN; sr=4'b0100 in both.
REQ-032 cond_valid=1 held, s_load C=1, reset asserted same cycle -> next cycle sr=0, cond_valid=0, cin_out=0.
REQ-033 s_load with C=1 -> cin_out=1 the cycle after edge; s_load=0 for 5 cycles with varying ALU flags -> sr, cin_out unchanged.
